// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to build in the parity bit (honours parity_odd).
module uart_tx_engine #(
    parameter int unsigned BAUD_DIV = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       parity_odd,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_done
);

    localparam int unsigned    CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic             podd_q, podd_d;
`else
    logic             unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef UART_TX_PARITY_EN
        podd_d  = podd_q;
`endif
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d  = din;
`ifdef UART_TX_PARITY_EN
                    podd_d  = parity_odd;
`endif
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they register without input-to-output paths.
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = (^data_d) ^ podd_d;
`endif
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            podd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            podd_q  <= podd_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine at BAUD_DIV=4.
// Expected frames are hand-written per build (UART_TX_PARITY_EN defined or not).
module tb_uart_tx_engine;

    localparam int unsigned B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
    // bit n of each constant is frame bit n (n=0 is the start bit)
    localparam logic [10:0] F55   = 11'b10010101010;
    localparam logic [10:0] F55_O = 11'b11010101010;
    localparam logic [10:0] F07   = 11'b11000001110;
    localparam logic [10:0] FA3   = 11'b10101000110;
    localparam logic [10:0] F0F   = 11'b10000011110;
`else
    localparam int unsigned NB = 10;
    localparam logic [10:0] F55   = 11'b01010101010;
    localparam logic [10:0] F55_O = 11'b01010101010;
    localparam logic [10:0] FA3   = 11'b01101000110;
    localparam logic [10:0] F0F   = 11'b01000011110;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       parity_odd = 1'b0;
    logic       tx, tx_ready, tx_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .din        (din),
        .parity_odd (parity_odd),
        .tx         (tx),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_idle(input string tag);
        check(tag, {29'd0, tx, tx_ready, tx_done}, 32'b110);
    endtask

    task automatic start(input logic [7:0] d, input logic podd);
        load = 1'b1;
        din = d;
        parity_odd = podd;
        tick;
        load = 1'b0;
        din = ~d;
        parity_odd = ~podd;
    endtask

    // Called just after the accepting edge; returns just after the edge that raises tx_done.
    task automatic expect_frame(input string tag, input logic [10:0] bits, input int glitch);
        for (int i = 0; i < int'(NB * B); i++) begin
            int n;
            n = i / int'(B);
            check($sformatf("%s tx bit%0d", tag, n), {31'd0, tx}, {31'd0, bits[n]});
            check($sformatf("%s busy bit%0d", tag, n), {30'd0, tx_ready, tx_done}, 32'd0);
            if (i == glitch) begin
                load = 1'b1;
                din = 8'hFF;
            end else begin
                load = 1'b0;
            end
            tick;
        end
        load = 1'b0;
        check({tag, " done"}, {29'd0, tx, tx_ready, tx_done}, 32'b111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        expect_idle("reset");
        for (int i = 0; i < 100; i++) begin
            tick;
            expect_idle("quiet");
        end

        start(8'h55, 1'b0);
        expect_frame("f55", F55, -1);
        tick;
        expect_idle("f55 after");

        start(8'h55, 1'b1);
        expect_frame("f55odd", F55_O, -1);
        tick;
        expect_idle("f55odd after");

`ifdef UART_TX_PARITY_EN
        start(8'h07, 1'b0);
        expect_frame("f07", F07, -1);
        tick;
        expect_idle("f07 after");
`endif

        start(8'h55, 1'b0);
        expect_frame("f55glitch", F55, 9);
        start(8'hA3, 1'b0);
        expect_frame("fA3b2b", FA3, -1);
        for (int i = 0; i < int'(2 * B); i++) begin
            tick;
            expect_idle("fA3 after");
        end

        start(8'h55, 1'b0);
        repeat (16) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        expect_idle("rst mid");
        for (int i = 0; i < int'(3 * B); i++) begin
            tick;
            expect_idle("rst quiet");
        end
        start(8'h0F, 1'b0);
        expect_frame("f0F", F0F, -1);
        tick;
        expect_idle("f0F after");

        reset = 1'b1;
        load = 1'b1;
        din = 8'h00;
        tick;
        reset = 1'b0;
        load = 1'b0;
        expect_idle("rst+load");
        for (int i = 0; i < int'(3 * B); i++) begin
            tick;
            expect_idle("rst+load quiet");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
